uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 184 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frames a stream of UART bytes into commands.
// Frame: SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK, where
// CHK = CMD ^ LEN ^ payload[0] ^ ... ^ payload[LEN-1].
// A good frame raises a one-cycle cmd_valid and updates cmd_*.
// A bad length, a bad checksum or an inter-byte timeout raises a
// one-cycle err_valid and updates err_code. cmd_* are left untouched.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 8,       // 1..8 payload bytes
  parameter int         TIMEOUT_CLKS = 520800   // must be at least 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_id,
  output logic [3:0]  cmd_len,
  output logic [63:0] cmd_payload,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  localparam int             TW        = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  // The counter is about to reach TIMEOUT_CLKS-1 when it holds this value.
  localparam logic [TW-1:0]  EXPIRE    = TW'(TIMEOUT_CLKS - 2);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  // Parser state and working registers.
  state_t        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [3:0]    len_q, len_d;
  logic [3:0]    idx_q, idx_d;
  logic [63:0]   buf_q, buf_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] timer_q, timer_d;

  // Next values of the registered outputs.
  logic          cmd_valid_d;
  logic [7:0]    cmd_id_d;
  logic [3:0]    cmd_len_d;
  logic [63:0]   cmd_payload_d;
  logic          err_valid_d;
  logic [1:0]    err_code_d;

  logic          timeout_hit;

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout_hit = (state_q != S_IDLE) && !rx_valid && (timer_q == EXPIRE);

  // Next-state, datapath and output decode for one byte (or one idle cycle).
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    xor_d         = xor_q;
    timer_d       = (state_q == S_IDLE || rx_valid) ? '0 : timer_q + TW'(1);
    cmd_valid_d   = 1'b0;
    cmd_id_d      = cmd_id;
    cmd_len_d     = cmd_len;
    cmd_payload_d = cmd_payload;
    err_valid_d   = 1'b0;
    err_code_d    = err_code;

    if (timeout_hit) begin
      state_d     = S_IDLE;
      timer_d     = '0;
      err_valid_d = 1'b1;
      err_code_d  = ERR_TMO;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          // Anything other than the sync marker is line noise.
          if (rx_data == SYNC_BYTE) begin
            state_d = S_CMD;
            buf_d   = '0;
            xor_d   = '0;
            idx_d   = '0;
            len_d   = '0;
          end
        end

        S_CMD: begin
          cmd_d   = rx_data;
          xor_d   = rx_data;
          state_d = S_LEN;
        end

        S_LEN: begin
          xor_d = xor_q ^ rx_data;
          len_d = rx_data[3:0];
          idx_d = '0;
          if (rx_data > MAX_LEN_B) begin
            state_d     = S_IDLE;
            err_valid_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else if (rx_data == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end

        S_PAYLOAD: begin
          buf_d[{idx_q[2:0], 3'b000} +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          idx_d = idx_q + 4'd1;
          if (idx_q + 4'd1 == len_q) begin
            state_d = S_CHK;
          end
        end

        S_CHK: begin
          state_d = S_IDLE;
          if (rx_data == xor_q) begin
            cmd_valid_d   = 1'b1;
            cmd_id_d      = cmd_q;
            cmd_len_d     = len_q;
            cmd_payload_d = buf_q;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, working registers and outputs, with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload buffer is a plain register bank, not a RAM, so it
      // is cleared by reset together with everything else.
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      xor_q       <= '0;
      timer_q     <= '0;
      cmd_valid   <= 1'b0;
      cmd_id      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_valid   <= 1'b0;
      err_code    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the previous cycle, independent of statement order.
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      xor_q       <= xor_d;
      timer_q     <= timer_d;
      cmd_valid   <= cmd_valid_d;
      cmd_id      <= cmd_id_d;
      cmd_len     <= cmd_len_d;
      cmd_payload <= cmd_payload_d;
      err_valid   <= err_valid_d;
      err_code    <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser. Inputs change and outputs are sampled
// on the falling edge; the DUT samples on the rising edge.
module tb_uart_cmd_parser;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_id;
  logic [3:0]  cmd_len;
  logic [63:0] cmd_payload;
  logic        err_valid;
  logic [1:0]  err_code;

  int checks   = 0;
  int failures = 0;

  uart_cmd_parser #(
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (8),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cmd_valid   (cmd_valid),
    .cmd_id      (cmd_id),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .err_valid   (err_valid),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobe cycle; returns on the next falling edge with rx_valid still
  // high, so consecutive calls give back-to-back strobes.
  task automatic drive_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".cmd_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, ".err_valid"}, 64'(err_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst.cmd_valid",   64'(cmd_valid),   64'd0);
    check("rst.err_valid",   64'(err_valid),   64'd0);
    check("rst.err_code",    64'(err_code),    64'd0);
    check("rst.cmd_id",      64'(cmd_id),      64'd0);
    check("rst.cmd_len",     64'(cmd_len),     64'd0);
    check("rst.cmd_payload", cmd_payload,      64'd0);
    rst_n = 1'b1;
    idle();

    // Good frame: CHK = 10^02^11^22 = 21.
    drive_byte(8'hA5); drive_byte(8'h10); drive_byte(8'h02);
    drive_byte(8'h11); drive_byte(8'h22);
    check_quiet("good.pre");
    drive_byte(8'h21);
    check("good.cmd_valid",   64'(cmd_valid), 64'd1);
    check("good.err_valid",   64'(err_valid), 64'd0);
    check("good.cmd_id",      64'(cmd_id),    64'h10);
    check("good.cmd_len",     64'(cmd_len),   64'd2);
    check("good.cmd_payload", cmd_payload,    64'h2211);
    idle();
    check("good.pulse_end",   64'(cmd_valid), 64'd0);

    // Bad checksum (55^01^77 = 23, sent 00): cmd_* keep the previous frame.
    drive_byte(8'hA5); drive_byte(8'h55); drive_byte(8'h01);
    drive_byte(8'h77); drive_byte(8'h00);
    check("badchk.err_valid",   64'(err_valid), 64'd1);
    check("badchk.err_code",    64'(err_code),  64'd1);
    check("badchk.cmd_valid",   64'(cmd_valid), 64'd0);
    check("badchk.cmd_id",      64'(cmd_id),    64'h10);
    check("badchk.cmd_len",     64'(cmd_len),   64'd2);
    check("badchk.cmd_payload", cmd_payload,    64'h2211);
    idle();
    check("badchk.pulse_end",   64'(err_valid), 64'd0);
    check("badchk.code_held",   64'(err_code),  64'd1);

    // Noise, then CMD=07, LEN=09 > MAX_LEN.
    drive_byte(8'h00); idle(); check_quiet("noise.00");
    drive_byte(8'hFF); idle(); check_quiet("noise.ff");
    drive_byte(8'hA5); drive_byte(8'h07);
    check_quiet("badlen.pre");
    drive_byte(8'h09);
    check("badlen.err_valid", 64'(err_valid), 64'd1);
    check("badlen.err_code",  64'(err_code),  64'd2);
    idle();
    check("badlen.pulse_end", 64'(err_valid), 64'd0);

    // Timeout: err_valid exactly TMO-1 cycles after the 01 strobe.
    drive_byte(8'hA5); drive_byte(8'h01);
    repeat (TMO - 2) idle();
    check("tmo.early",      64'(err_valid), 64'd0);
    idle();
    check("tmo.err_valid",  64'(err_valid), 64'd1);
    check("tmo.err_code",   64'(err_code),  64'd3);
    check("tmo.cmd_valid",  64'(cmd_valid), 64'd0);
    idle();
    check("tmo.pulse_end",  64'(err_valid), 64'd0);
    check("tmo.cmd_id",     64'(cmd_id),    64'h10);

    // 9th byte lands on the expiry cycle: no timeout.
    // CHK = 20^06^01^02^03^04^05^06 = 21.
    drive_byte(8'hA5); drive_byte(8'h20); drive_byte(8'h06);
    drive_byte(8'h01); drive_byte(8'h02); drive_byte(8'h03);
    drive_byte(8'h04); drive_byte(8'h05);
    rx_valid = 1'b0;
    repeat (TMO - 2) idle();
    drive_byte(8'h06);
    check("race.no_err",      64'(err_valid), 64'd0);
    drive_byte(8'h21);
    check("race.cmd_valid",   64'(cmd_valid), 64'd1);
    check("race.cmd_len",     64'(cmd_len),   64'd6);
    check("race.cmd_payload", cmd_payload,    64'h0000_0605_0403_0201);
    idle();

    // LEN == MAX_LEN. CHK = 40^08^(01^..^08 = 08) = 40.
    drive_byte(8'hA5); drive_byte(8'h40); drive_byte(8'h08);
    for (int i = 1; i <= 8; i++) drive_byte(8'(i));
    drive_byte(8'h40);
    check("max.cmd_valid",   64'(cmd_valid), 64'd1);
    check("max.cmd_id",      64'(cmd_id),    64'h40);
    check("max.cmd_len",     64'(cmd_len),   64'd8);
    check("max.cmd_payload", cmd_payload,    64'h0807_0605_0403_0201);
    idle();

    // Sync value as data, zero-length frames back to back.
    drive_byte(8'hA5); drive_byte(8'hA5); drive_byte(8'h00); drive_byte(8'hA5);
    check("b2b1.cmd_valid",   64'(cmd_valid), 64'd1);
    check("b2b1.cmd_id",      64'(cmd_id),    64'hA5);
    check("b2b1.cmd_len",     64'(cmd_len),   64'd0);
    check("b2b1.cmd_payload", cmd_payload,    64'd0);
    drive_byte(8'hA5);
    check("b2b1.pulse_end",   64'(cmd_valid), 64'd0);
    drive_byte(8'h30); drive_byte(8'h00); drive_byte(8'h30);
    check("b2b2.cmd_valid",   64'(cmd_valid), 64'd1);
    check("b2b2.cmd_id",      64'(cmd_id),    64'h30);
    check("b2b2.err_valid",   64'(err_valid), 64'd0);
    idle();

    // Reset mid-frame: partial frame dropped silently.
    drive_byte(8'hA5); drive_byte(8'h10); drive_byte(8'h02); drive_byte(8'h11);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst.err_valid",   64'(err_valid), 64'd0);
    check("mid_rst.cmd_id",      64'(cmd_id),    64'd0);
    check("mid_rst.cmd_len",     64'(cmd_len),   64'd0);
    check("mid_rst.cmd_payload", cmd_payload,    64'd0);
    check("mid_rst.err_code",    64'(err_code),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TMO + 2) idle();
    check_quiet("post_rst.idle");
    drive_byte(8'hA5); drive_byte(8'h10); drive_byte(8'h02);
    drive_byte(8'h11); drive_byte(8'h22); drive_byte(8'h21);
    check("post_rst.cmd_valid",   64'(cmd_valid), 64'd1);
    check("post_rst.cmd_payload", cmd_payload,    64'h2211);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
